video_timing_gen: RTL and testbench

//  Generates raster timing (CE_PIXEL, HBLANK, VBLANK, HSYNC, VSYNC) plus pixel coordinates for cores and test patterns.

---
 rtl/video_timing_gen.sv | 179 +++++++++++++++++
 tb/tb_video_timing_gen.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : video_timing_gen
// Description : Raster timing generator (pixel strobe, blanking, sync, x/y).
// Revision    : 1.0 - initial release
// ============================================================================
module video_timing_gen #(
  parameter int   CE_DIV   = 4,
  parameter int   H_ACTIVE = 320,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 32,
  parameter int   H_BP     = 32,
  parameter int   V_ACTIVE = 240,
  parameter int   V_FP     = 4,
  parameter int   V_SYNC   = 4,
  parameter int   V_BP     = 14,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic        CE_PIXEL,
  output logic        HBLANK,
  output logic        VBLANK,
  output logic        HSYNC,
  output logic        VSYNC,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        frame_start
);

  localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [3:0]  c_ce_last  = 4'(CE_DIV - 1);
  localparam logic [11:0] c_h_last   = 12'(c_h_total - 1);
  localparam logic [11:0] c_v_last   = 12'(c_v_total - 1);
  localparam logic [12:0] c_h_active = 13'(H_ACTIVE);
  localparam logic [12:0] c_hs_start = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] c_hs_end   = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] c_v_active = 13'(V_ACTIVE);
  localparam logic [12:0] c_vs_start = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] c_vs_end   = 13'(V_ACTIVE + V_FP + V_SYNC);

  if (CE_DIV < 1 || CE_DIV > 16) begin : g_bad_ce_div
    $error("video_timing_gen: CE_DIV must be 1..16");
  end
  if (c_h_total < 2 || c_h_total > 4096) begin : g_bad_h_total
    $error("video_timing_gen: horizontal total must be 2..4096");
  end
  if (c_v_total < 2 || c_v_total > 4096) begin : g_bad_v_total
    $error("video_timing_gen: vertical total must be 2..4096");
  end
  if (H_ACTIVE < 1 || H_SYNC < 1 || H_FP < 0 || H_BP < 0) begin : g_bad_h_region
    $error("video_timing_gen: illegal horizontal region size");
  end
  if (V_ACTIVE < 1 || V_SYNC < 1 || V_FP < 0 || V_BP < 0) begin : g_bad_v_region
    $error("video_timing_gen: illegal vertical region size");
  end

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_ce_cnt;
  logic [3:0]  w_ce_nxt;
  logic [11:0] r_h_cnt;
  logic [11:0] w_h_nxt;
  logic [11:0] r_v_cnt;
  logic [11:0] w_v_nxt;

  logic        w_run_nxt;
  logic [12:0] w_h_ext;
  logic [12:0] w_v_ext;
  logic        w_ce_pixel_nxt;
  logic        w_hblank_nxt;
  logic        w_vblank_nxt;
  logic        w_hsync_nxt;
  logic        w_vsync_nxt;
  logic        w_frame_start_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_ce_cnt <= '0;
      r_h_cnt  <= '0;
      r_v_cnt  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ce_cnt <= w_ce_nxt;
      r_h_cnt  <= w_h_nxt;
      r_v_cnt  <= w_v_nxt;
    end
  end

  // The first enabled cycle holds (0,0,0); counting starts on the cycle after.
  always_comb begin
    w_state_nxt = r_state;
    w_ce_nxt    = r_ce_cnt;
    w_h_nxt     = r_h_cnt;
    w_v_nxt     = r_v_cnt;
    case (r_state)
      S_IDLE: begin
        w_ce_nxt = '0;
        w_h_nxt  = '0;
        w_v_nxt  = '0;
        if (enable) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (!enable) begin
          w_state_nxt = S_IDLE;
          w_ce_nxt    = '0;
          w_h_nxt     = '0;
          w_v_nxt     = '0;
        end else if (r_ce_cnt == c_ce_last) begin
          w_ce_nxt = '0;
          if (r_h_cnt == c_h_last) begin
            w_h_nxt = '0;
            w_v_nxt = (r_v_cnt == c_v_last) ? 12'd0 : r_v_cnt + 12'd1;
          end else begin
            w_h_nxt = r_h_cnt + 12'd1;
          end
        end else begin
          w_ce_nxt = r_ce_cnt + 4'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_ce_nxt    = '0;
        w_h_nxt     = '0;
        w_v_nxt     = '0;
      end
    endcase
  end

  // Outputs decode the next counter values so the registered flags line up
  // with the x/y registered alongside them.
  always_comb begin
    w_run_nxt         = (w_state_nxt == S_RUN);
    w_h_ext           = {1'b0, w_h_nxt};
    w_v_ext           = {1'b0, w_v_nxt};
    w_ce_pixel_nxt    = w_run_nxt && (w_ce_nxt == c_ce_last);
    w_hblank_nxt      = !w_run_nxt || (w_h_ext >= c_h_active);
    w_vblank_nxt      = !w_run_nxt || (w_v_ext >= c_v_active);
    w_hsync_nxt       = w_run_nxt && (w_h_ext >= c_hs_start) && (w_h_ext < c_hs_end);
    w_vsync_nxt       = w_run_nxt && (w_v_ext >= c_vs_start) && (w_v_ext < c_vs_end);
    w_frame_start_nxt = w_ce_pixel_nxt && (w_h_nxt == 12'd0) && (w_v_nxt == 12'd0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      CE_PIXEL    <= 1'b0;
      HBLANK      <= 1'b1;
      VBLANK      <= 1'b1;
      HSYNC       <= ~HS_POL;
      VSYNC       <= ~VS_POL;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
    end else begin
      CE_PIXEL    <= w_ce_pixel_nxt;
      HBLANK      <= w_hblank_nxt;
      VBLANK      <= w_vblank_nxt;
      HSYNC       <= w_hsync_nxt ? HS_POL : ~HS_POL;
      VSYNC       <= w_vsync_nxt ? VS_POL : ~VS_POL;
      x           <= w_h_nxt;
      y           <= w_v_nxt;
      frame_start <= w_frame_start_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_video_timing_gen
// Description : Scoreboard bench for video_timing_gen (CE_DIV=2 and CE_DIV=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_video_timing_gen;

  logic clk;
  logic reset_n;
  logic enable;

  logic        ce0, hb0, vb0, hs0, vs0, fs0;
  logic [11:0] x0, y0;
  logic        ce1, hb1, vb1, hs1, vs1, fs1;
  logic [11:0] x1, y1;

  video_timing_gen #(
    .CE_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(4),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2), .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .CE_PIXEL(ce0), .HBLANK(hb0), .VBLANK(vb0), .HSYNC(hs0), .VSYNC(vs0),
    .x(x0), .y(y0), .frame_start(fs0)
  );

  video_timing_gen #(
    .CE_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(4),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2), .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_dut1 (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .CE_PIXEL(ce1), .HBLANK(hb1), .VBLANK(vb1), .HSYNC(hs1), .VSYNC(vs1),
    .x(x1), .y(y1), .frame_start(fs1)
  );

  // {CE_PIXEL, HBLANK, VBLANK, HSYNC, VSYNC, frame_start, x, y}
  logic [29:0] obs0, obs1;
  assign obs0 = {ce0, hb0, vb0, hs0, vs0, fs0, x0, y0};
  assign obs1 = {ce1, hb1, vb1, hs1, vs1, fs1, x1, y1};

  localparam logic [29:0] IDLE_VEC = {6'b011000, 12'd0, 12'd0};

  typedef struct packed {
    logic [29:0] a;
    logic [29:0] b;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   m_run   = 1'b0;
  int   m_t     = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // Reference raster built from an absolute tick count since start.
  function automatic logic [29:0] model(input bit run, input int t, input int ce_div);
    int ce, p, h, v;
    logic c, hb, vb, hs, vs, fs;
    if (!run) return IDLE_VEC;
    ce = t % ce_div;
    p  = t / ce_div;
    h  = p % 16;
    v  = (p / 16) % 8;
    c  = (ce == ce_div - 1);
    hb = (h >= 8);
    vb = (v >= 4);
    hs = (h >= 10) && (h < 12);
    vs = (v == 5);
    fs = c && (h == 0) && (v == 0);
    return {c, hb, vb, hs, vs, fs, 12'(h), 12'(v)};
  endfunction

  task automatic tick(input logic en);
    enable = en;
    @(posedge clk);
    if (!en) begin
      m_run = 1'b0;
      m_t   = 0;
    end else if (!m_run) begin
      m_run = 1'b1;
      m_t   = 0;
    end else begin
      m_t = m_t + 1;
    end
    sb.push_back('{a: model(m_run, m_t, 2), b: model(m_run, m_t, 1)});
    @(negedge clk);
  endtask

  task automatic test_reset;
    exp_t e;
    reset_n = 1'b0;
    enable  = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (obs0 !== IDLE_VEC) begin
      n_fail++;
      $display("FAIL reset_state_div2: got %h expected %h", obs0, IDLE_VEC);
    end
    n_tests++;
    if (obs1 !== IDLE_VEC) begin
      n_fail++;
      $display("FAIL reset_state_div1: got %h expected %h", obs1, IDLE_VEC);
    end
    reset_n = 1'b1;
    m_run   = 1'b0;
    m_t     = 0;
    for (int k = 0; k < 2; k++) begin
      tick(1'b0);
      e = sb.pop_front();
      n_tests++;
      if (obs0 !== e.a || obs1 !== e.b) begin
        n_fail++;
        $display("FAIL idle_hold: got %h/%h expected %h/%h", obs0, obs1, e.a, e.b);
      end
    end
  endtask

  task automatic test_startup;
    exp_t e;
    for (int k = 0; k < 40; k++) begin
      tick(1'b1);
      e = sb.pop_front();
      n_tests++;
      if (obs0 !== e.a || obs1 !== e.b) begin
        n_fail++;
        $display("FAIL startup_k%0d: got %h/%h expected %h/%h", k, obs0, obs1, e.a, e.b);
      end
      if (k == 0) begin
        n_tests++;
        if (hb0 !== 1'b0 || ce0 !== 1'b0) begin
          n_fail++;
          $display("FAIL startup_first_cycle: got hb=%b ce=%b expected hb=0 ce=0", hb0, ce0);
        end
      end
      if (k == 1) begin
        n_tests++;
        if (ce0 !== 1'b1 || fs0 !== 1'b1) begin
          n_fail++;
          $display("FAIL startup_first_ce: got ce=%b fs=%b expected ce=1 fs=1", ce0, fs0);
        end
      end
      if (k == 15 || k == 16) begin
        n_tests++;
        if (hb0 !== (k == 16)) begin
          n_fail++;
          $display("FAIL startup_hblank_rise_k%0d: got %b expected %b", k, hb0, (k == 16));
        end
      end
    end
  endtask

  task automatic test_frames;
    exp_t e;
    int lc, lce, lu, lp, ly, lyu;
    int x_clk, x_ce, x_unb, x_pix, y_lines, y_unb;
    int hs_len, vs_len;
    bit have_line, have_frame, p_hb, p_vb, p_hs, p_vs;
    lc = 0; lce = 0; lu = 0; lp = 0; ly = 0; lyu = 0;
    x_clk = -1; x_ce = -1; x_unb = -1; x_pix = -1; y_lines = -1; y_unb = -1;
    hs_len = 0; vs_len = 0;
    have_line = 0; have_frame = 0;
    tick(1'b0);
    e = sb.pop_front();
    p_hb = 1; p_vb = 1; p_hs = 0; p_vs = 0;
    for (int k = 0; k < 530; k++) begin
      tick(1'b1);
      e = sb.pop_front();
      n_tests++;
      if (obs0 !== e.a || obs1 !== e.b) begin
        n_fail++;
        $display("FAIL frames_k%0d: got %h/%h expected %h/%h", k, obs0, obs1, e.a, e.b);
      end
      if (p_hb && !hb0) begin
        if (have_line) begin
          x_clk = lc; x_ce = lce; x_unb = lu; x_pix = lp;
        end
        lc = 0; lce = 0; lu = 0; lp = 0;
        have_line = 1;
      end
      if (p_vb && !vb0) begin
        if (have_frame) begin
          y_lines = ly; y_unb = lyu;
        end
        ly = 0; lyu = 0;
        have_frame = 1;
      end
      if (p_hb && !hb0) begin
        ly++;
        if (!vb0) lyu++;
      end
      lc++;
      if (ce0) lce++;
      if (!hb0) lu++;
      if (ce0 && !hb0) lp++;
      if (!p_hs && hs0) begin
        hs_len = 1;
        n_tests++;
        if (x0 !== 12'd10) begin
          n_fail++;
          $display("FAIL hsync_start: got x=%0d expected 10", x0);
        end
      end else if (hs0) hs_len++;
      if (p_hs && !hs0) begin
        n_tests++;
        if (hs_len != 4) begin
          n_fail++;
          $display("FAIL hsync_width: got %0d expected 4", hs_len);
        end
      end
      if (!p_vs && vs0) begin
        vs_len = 1;
        n_tests++;
        if (y0 !== 12'd5 || x0 !== 12'd0) begin
          n_fail++;
          $display("FAIL vsync_start: got x=%0d y=%0d expected x=0 y=5", x0, y0);
        end
      end else if (vs0) vs_len++;
      if (p_vs && !vs0) begin
        n_tests++;
        if (vs_len != 32) begin
          n_fail++;
          $display("FAIL vsync_width: got %0d expected 32", vs_len);
        end
      end
      p_hb = hb0; p_vb = vb0; p_hs = hs0; p_vs = vs0;
    end
    n_tests++;
    if (x_clk != 32 || x_ce != 16 || x_unb != 16 || x_pix != 8) begin
      n_fail++;
      $display("FAIL readback_x: got %0d/%0d/%0d/%0d expected 32/16/16/8", x_clk, x_ce, x_unb, x_pix);
    end
    n_tests++;
    if (y_lines != 8 || y_unb != 4) begin
      n_fail++;
      $display("FAIL readback_y: got %0d/%0d expected 8/4", y_lines, y_unb);
    end
  endtask

  task automatic test_ce_div1;
    exp_t e;
    int last_hb, last_fs;
    bit p_hb;
    last_hb = -1; last_fs = -1;
    tick(1'b0);
    e = sb.pop_front();
    p_hb = 1;
    for (int k = 0; k < 300; k++) begin
      tick(1'b1);
      e = sb.pop_front();
      n_tests++;
      if (obs1 !== e.b || obs0 !== e.a) begin
        n_fail++;
        $display("FAIL div1_k%0d: got %h/%h expected %h/%h", k, obs0, obs1, e.a, e.b);
      end
      n_tests++;
      if (ce1 !== 1'b1) begin
        n_fail++;
        $display("FAIL div1_ce_const_k%0d: got %b expected 1", k, ce1);
      end
      if (p_hb && !hb1) begin
        if (last_hb >= 0) begin
          n_tests++;
          if (k - last_hb != 16) begin
            n_fail++;
            $display("FAIL div1_hblank_period: got %0d expected 16", k - last_hb);
          end
        end
        last_hb = k;
      end
      if (fs1) begin
        if (last_fs >= 0) begin
          n_tests++;
          if (k - last_fs != 128) begin
            n_fail++;
            $display("FAIL div1_frame_period: got %0d expected 128", k - last_fs);
          end
        end
        last_fs = k;
      end
      p_hb = hb1;
    end
  endtask

  task automatic test_enable_drop;
    exp_t e;
    bit found;
    found = 0;
    for (int k = 0; k < 600 && !found; k++) begin
      tick(1'b1);
      e = sb.pop_front();
      n_tests++;
      if (obs0 !== e.a || obs1 !== e.b) begin
        n_fail++;
        $display("FAIL drop_run_k%0d: got %h/%h expected %h/%h", k, obs0, obs1, e.a, e.b);
      end
      if (x0 == 12'd5 && y0 == 12'd2) found = 1;
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL drop_reach_x5_y2: got not reached expected reached within 600 clks");
    end
    for (int k = 0; k < 3; k++) begin
      tick(1'b0);
      e = sb.pop_front();
      n_tests++;
      if (obs0 !== IDLE_VEC || obs1 !== e.b) begin
        n_fail++;
        $display("FAIL drop_idle_k%0d: got %h/%h expected %h/%h", k, obs0, obs1, IDLE_VEC, e.b);
      end
    end
    tick(1'b1);
    e = sb.pop_front();
    n_tests++;
    if (obs0 !== e.a || x0 !== 12'd0 || y0 !== 12'd0 || hb0 !== 1'b0 || ce0 !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_origin: got %h expected %h", obs0, e.a);
    end
    tick(1'b1);
    e = sb.pop_front();
    n_tests++;
    if (ce0 !== 1'b1 || fs0 !== 1'b1 || obs0 !== e.a) begin
      n_fail++;
      $display("FAIL restart_frame_start: got %h expected %h", obs0, e.a);
    end
  endtask

  task automatic test_async_reset;
    exp_t e;
    for (int k = 0; k < 7; k++) begin
      tick(1'b1);
      e = sb.pop_front();
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (obs0 !== IDLE_VEC || obs1 !== IDLE_VEC) begin
      n_fail++;
      $display("FAIL async_reset_immediate: got %h/%h expected %h", obs0, obs1, IDLE_VEC);
    end
    m_run = 1'b0;
    m_t   = 0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (obs0 !== IDLE_VEC) begin
      n_fail++;
      $display("FAIL async_reset_hold: got %h expected %h", obs0, IDLE_VEC);
    end
    reset_n = 1'b1;
    test_startup();
  endtask

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    test_reset();
    test_startup();
    test_frames();
    test_ce_div1();
    test_enable_drop();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
